// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end of the 32x32 register file.
//   Accepts ALU and load results over valid/ready, extends load data, queues
//   results in an in-order FIFO of DEPTH entries and retires one register-file
//   write per cycle, while tracking outstanding writes in a pending scoreboard.
// Ports:
//   clk, rst (async active-low)
//   alu_valid/alu_rd/alu_data -> alu_ready            ALU result input
//   mem_valid/mem_rd/mem_data/mem_size/mem_unsigned -> mem_ready   load input
//   issue_valid/issue_rd                                marks rd pending
//   rf_we/rf_rd/rf_data                                 register-file write
//   pending                                             outstanding-write mask
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic [31:0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pending_q, pending_d;
    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          push_m, push_a, sx;
    logic [31:0]   mem_ext, set_m, clr_m;
    // Readiness uses the registered count only; a same-cycle pop earns no credit.
    assign mem_ready = count_q < CW'(DEPTH);
    assign alu_ready = mem_ready && (!mem_valid || count_q <= CW'(DEPTH - 2));
    // Destination x0 completes the handshake but never occupies a slot.
    assign push_m    = mem_valid && mem_ready && mem_rd != 5'd0;
    assign push_a    = alu_valid && alu_ready && alu_rd != 5'd0;
    assign sx        = !mem_unsigned && (mem_size == 2'd0 ? mem_data[7] : mem_data[15]);
    assign mem_ext   = mem_size == 2'd0 ? {{24{sx}}, mem_data[7:0]} :
                       mem_size == 2'd1 ? {{16{sx}}, mem_data[15:0]} : mem_data;
    assign rf_we     = count_q != '0;
    assign rf_rd     = rf_we ? rd_q[rp_q] : 5'd0;
    assign rf_data   = rf_we ? data_q[rp_q] : 32'd0;
    assign pending   = pending_q;
    always_comb begin
        wp_d      = wp_q + AW'(push_m) + AW'(push_a);
        rp_d      = rp_q + AW'(rf_we);
        count_d   = count_q + CW'(push_m) + CW'(push_a) - CW'(rf_we);
        set_m     = issue_valid ? 32'd1 << issue_rd : 32'd0;
        clr_m     = rf_we ? 32'd1 << rf_rd : 32'd0;
        // Applying the set after the clear makes a same-edge issue win.
        pending_d = ((pending_q & ~clr_m) | set_m) & ~32'd1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end
    // The load entry is older, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (push_m) begin
            rd_q[wp_q]   <= mem_rd;
            data_q[wp_q] <= mem_ext;
        end
        if (push_a) begin
            rd_q[wp_q + AW'(push_m)]   <= alu_rd;
            data_q[wp_q + AW'(push_m)] <= alu_data;
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and randomized checks of reg_writeback against a queue model.
module tb_reg_writeback;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0, mem_unsigned = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic [1:0]  mem_size = '0;
    logic        alu_ready, mem_ready, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data, pending;
    int          errors = 0, checks = 0;
    logic [4:0]  qr[$];
    logic [31:0] qd[$];
    logic [31:0] mp = '0;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic logic [31:0] ext(logic [31:0] d, logic [1:0] s, logic u);
        longint v;
        v = d;
        if (s == 2'd0) begin
            v = d % 256;
            if (!u && v >= 128) v += 64'hFFFF_FF00;
        end else if (s == 2'd1) begin
            v = d % 65536;
            if (!u && v >= 32768) v += 64'hFFFF_0000;
        end
        return v[31:0];
    endfunction

    // Inputs change only just after a falling edge, so at each falling edge the
    // inputs are the ones the preceding rising edge saw.
    initial forever begin
        int fr;
        bit mr, ar;
        @(negedge clk);
        if (!rst) begin
            qr.delete();
            qd.delete();
            mp = '0;
        end else begin
            fr = DEPTH - qr.size();
            mr = fr >= 1;
            ar = fr >= 1 && (!mem_valid || fr >= 2);
            if (qr.size() != 0) begin
                mp[qr[0]] = 1'b0;
                void'(qr.pop_front());
                void'(qd.pop_front());
            end
            if (mem_valid && mr && mem_rd != 0) begin
                qr.push_back(mem_rd);
                qd.push_back(ext(mem_data, mem_size, mem_unsigned));
            end
            if (alu_valid && ar && alu_rd != 0) begin
                qr.push_back(alu_rd);
                qd.push_back(alu_data);
            end
            if (issue_valid && issue_rd != 0) mp[issue_rd] = 1'b1;
            mp[0] = 1'b0;
        end
        fr = DEPTH - qr.size();
        chk("rf_we", 32'(rf_we), 32'(qr.size() != 0));
        chk("rf_rd", 32'(rf_rd), qr.size() != 0 ? 32'(qr[0]) : 32'd0);
        chk("rf_data", rf_data, qd.size() != 0 ? qd[0] : 32'd0);
        chk("mem_ready", 32'(mem_ready), 32'(fr >= 1));
        chk("alu_ready", 32'(alu_ready), 32'(fr >= 1 && (!mem_valid || fr >= 2)));
        chk("pending", pending, mp);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        issue_valid = 1'b0;
    endtask

    logic [1:0]  sz_t [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        un_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8080, 32'h0000_8080};

    initial begin
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_ready", {alu_ready, mem_ready}, 32'd3);
        // single ALU write
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        chk("pend5_set", 32'(pending[5]), 32'd1);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_rd", 32'(rf_rd), 32'd5);
        chk("alu_data", rf_data, 32'h1234_5678);
        tick();
        chk("pend5_clr", 32'(pending[5]), 32'd0);
        // load extension
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_8080;
            mem_size = sz_t[i]; mem_unsigned = un_t[i];
            tick();
            mem_valid = 1'b0;
            chk($sformatf("ext%0d", i), rf_data, ex_t[i]);
            tick();
        end
        // simultaneous sources, load entry first
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'd1; mem_size = 2'd2;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd2;
        #1;
        chk("dual_ready", {alu_ready, mem_ready}, 32'd3);
        tick();
        idle();
        chk("dual_first", {rf_rd, rf_data[26:0]}, {5'd3, 27'd1});
        tick();
        chk("dual_second", {rf_rd, rf_data[26:0]}, {5'd4, 27'd2});
        tick();
        chk("dual_empty", 32'(rf_we), 32'd0);
        // fill to one free slot: only the load is accepted
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
        repeat (2) tick();
        #1;
        chk("free1_alu", 32'(alu_ready), 32'd0);
        chk("free1_mem", 32'(mem_ready), 32'd1);
        tick();
        idle();
        repeat (4) tick();
        // six back-to-back ALU results all accepted
        for (int i = 1; i <= 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'(i * 17);
            #1;
            chk("stream_ready", 32'(alu_ready), 32'd1);
            tick();
            chk("stream_rd", 32'(rf_rd), 32'(i));
        end
        idle();
        tick();
        // x0 destination
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        #1;
        chk("x0_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        chk("x0_nowrite", 32'(rf_we), 32'd0);
        // issue collides with the retiring write to x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        chk("x7_write", 32'(rf_rd), 32'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("x7_setwins", 32'(pending[7]), 32'd1);
        // reset with three entries queued
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h12;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
        repeat (2) tick();
        idle();
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_pend", pending, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we", 32'(rf_we), 32'd0);
        end
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            mem_valid = 1'($urandom % 2); mem_rd = 5'($urandom % 32);
            mem_data = $urandom; mem_size = 2'($urandom % 4); mem_unsigned = 1'($urandom % 2);
            alu_valid = 1'($urandom % 2); alu_rd = 5'($urandom % 32); alu_data = $urandom;
            issue_rd = 5'($urandom % 32);
            issue_valid = 1'($urandom % 2) && !mp[issue_rd];
            if (n % 300 == 299) rst = 1'b0;
            else rst = 1'b1;
            tick();
        end
        idle();
        repeat (6) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
